mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (LW/SW/SB data accesses) of the pipelined MIPS core. It sits between the IF/MEM stages and the memory model. It latches one request at a time, drives the memory handshake, and returns a one-cycle ready pulse with the read data. The pipeline stalls each stage on its `req & ~ready`.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, input, 1: single clock.
  - `rst`, input, 1: asynchronous, active-high reset.
- Fetch port:
  - `if_req`, input, 1: fetch read request; held until `if_ready`.
  - `if_addr`, input, ADDR_W: fetch word address.
  - `if_rdata`, output, DATA_W: fetched instruction; valid when `if_ready` is high.
  - `if_ready`, output, 1: one-cycle completion pulse for fetch.
- Data port:
  - `dm_req`, input, 1: data request; held until `dm_ready`.
  - `dm_we`, input, 1: 1 selects write (SW/SB), 0 selects read (LW).
  - `dm_be`, input, DATA_W/8: byte enables (SW = 4'b1111; SB = one-hot).
  - `dm_addr`, input, ADDR_W: data address.
  - `dm_wdata`, input, DATA_W: data to write.
  - `dm_rdata`, output, DATA_W: load data; valid when `dm_ready` is high on a read.
  - `dm_ready`, output, 1: one-cycle completion pulse for data.
- Memory port:
  - `mem_req`, output, 1: request to memory; held until `mem_ack`.
  - `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, outputs: registered copies of the granted request.
  - `mem_rdata`, input, DATA_W: read data; sampled when `mem_ack` is high.
  - `mem_ack`, input, 1: memory done. May arrive in the same cycle `mem_req` rises, or any number of cycles later.
- Status:
  - `busy`, output, 1: a transaction is outstanding (state is not IDLE).
  - `grant_dm`, output, 1: owner of the current or most recent transaction (1 = data port, 0 = fetch port).

## Operation
- FSM states:
  - IDLE.
  - IF_XFER.
  - DM_XFER.
- Eligibility in IDLE: a port is eligible if its `req` is high and its `ready` is not high in that same cycle. This masks a stale request in the cycle after completion.
- Arbitration in IDLE:
  - Only one port eligible: grant it.
  - Both eligible: round-robin against `grant_dm`. Grant fetch if `grant_dm`=1, otherwise grant data.
  - After reset `grant_dm`=0, so data wins the first tie.
- On grant:
  - Latch `we`/`be`/`addr`/`wdata` into the memory-port registers (fetch forces `we`=0 and `be`=all ones).
  - Set `grant_dm`.
  - Go to the matching XFER state.
  - `mem_req` is 1 in every XFER cycle.
- In XFER, when `mem_ack`=1:
  - Capture `mem_rdata` into the owner's rdata register.
  - Pulse the owner's `ready` in the next cycle.
  - Return to IDLE.
  - Data writes do not update `dm_rdata`; it holds its previous value.
- Requests are not re-sampled during XFER. If a requester drops `req` mid-transaction, the transaction still completes and `ready` still pulses.
- Outside XFER:
  - `mem_ack` is ignored.
  - `mem_req`=0.
  - `mem_we`=0.
- The arbiter passes addresses through unchanged and performs no alignment checks.

## Timing
- Reset values:
  - State is IDLE.
  - `mem_req`, `mem_we`, `if_ready`, `dm_ready`, `busy`, `grant_dm` are 0.
  - `mem_be`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` are all 0.
- Reset during a transfer aborts it immediately. `mem_req` drops asynchronously and no `ready` pulse is issued.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency, with the request seen in IDLE at cycle T:
  - `mem_req` is high from T+1.
  - With `mem_ack` at T+1+k (k≥0), `ready` is high at T+2+k for exactly one cycle and state is IDLE at T+2+k.
  - Minimum latency is 2 cycles.
- Back-to-back: a new request from either port held at T+2+k is granted that cycle if eligible. The port just completed is not eligible until T+3+k.
- Throughput: at most one transfer is in flight; peak rate is one per 2 cycles.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x0040_0000, memory acks the first cycle with 0x2408_0005. Required: `mem_req` high 1 cycle, `if_ready` pulse 2 cycles after the request, `if_rdata`=0x2408_0005, `dm_ready` stays 0.
- **Simultaneous requests after reset:** fetch 0x0040_0004 and LW 0x1001_0000 raised together, ack latency 0. Required: data granted first (`grant_dm`=1, `dm_ready` at cycle 2), then fetch (`if_ready` at cycle 4). With both held continuously, grants alternate DM, IF, DM, IF.
- **SB with wait states:** `dm_we`=1, `dm_be`=4'b0100, `dm_addr`=0x1001_0002, `dm_wdata`=0x00AB_0000, memory acks after 3 cycles. Required: `mem_req` high for exactly 4 cycles with stable `mem_be`/`mem_addr`/`mem_wdata`, `dm_ready` at cycle 5, `dm_rdata` unchanged.
- **Stale request masking:** fetch holds `if_req` one cycle past `if_ready`, with no data request. Required: no second transfer (`mem_req` stays 0) in the masked cycle.
- **Reset mid-transfer:** assert `rst` while in DM_XFER, then raise `mem_ack` after reset releases. Required: `mem_req`=0 immediately, no `dm_ready` pulse, ack ignored, all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch port and the
// data port. One transaction in flight; round-robin on simultaneous requests;
// every output comes straight from a flop.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ready,
  // data port
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_W/8-1:0]   dm_be,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_ready,
  // memory port
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  // status
  output logic                  busy,
  output logic                  grant_dm
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    DM_XFER = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic                busy_q, busy_d;
  logic                grant_dm_q, grant_dm_d;

  logic                if_elig, dm_elig, pick_dm;

  // Next-state: arbitrate in IDLE, wait for the ack in XFER
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    busy_d      = busy_q;
    grant_dm_d  = grant_dm_q;

    // a requester still holding req in its ready cycle is a stale request
    if_elig = if_req & ~if_ready_q;
    dm_elig = dm_req & ~dm_ready_q;
    pick_dm = dm_elig & (~if_elig | ~grant_dm_q);

    unique case (state_q)
      IDLE: begin
        if (pick_dm) begin
          state_d     = DM_XFER;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_be_d    = dm_be;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          busy_d      = 1'b1;
          grant_dm_d  = 1'b1;
        end else if (if_elig) begin
          state_d     = IF_XFER;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = {BE_W{1'b1}};
          mem_addr_d  = if_addr;
          busy_d      = 1'b1;
          grant_dm_d  = 1'b0;
        end
      end
      IF_XFER: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          busy_d     = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
        end
      end
      DM_XFER: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          busy_d     = 1'b0;
          dm_ready_d = 1'b1;
          // stores leave the load-data register untouched
          if (!mem_we_q) dm_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_dm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      busy_q      <= busy_d;
      grant_dm_q  <= grant_dm_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign busy      = busy_q;
  assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a small memory model, and a
// scoreboard monitor that checks read data whenever a ready pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic        busy;
  logic        grant_dm;

  logic        ack_model = 1'b0;
  logic        ack_force = 1'b0;
  int          ack_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_img [logic [31:0]];

  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];

  assign mem_ack = ack_model | ack_force;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant_dm(grant_dm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_if_ready"},  32'(if_ready),  32'd0);
    chk({tag, "_dm_ready"},  32'(dm_ready),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_grant_dm"},  32'(grant_dm),  32'd0);
    chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_if_rdata"},  if_rdata,       32'd0);
    chk({tag, "_dm_rdata"},  dm_rdata,       32'd0);
  endtask

  // Memory model: ack after ack_lat wait cycles, read data from mem_img
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      ack_model <= 1'b0;
      wait_cnt  <= 0;
    end else if (wait_cnt == ack_lat) begin
      ack_model <= 1'b1;
      wait_cnt  <= 0;
      mem_rdata <= mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'hFFFF_FFFF;
    end else begin
      ack_model <= 1'b0;
      wait_cnt  <= wait_cnt + 1;
    end
  end

  // Scoreboard monitor: every ready pulse must match the next expected datum
  always @(negedge clk) begin
    if (!rst) begin
      if (if_ready) begin
        if (exp_if_q.size() == 0) chk("if_ready_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (dm_ready) begin
        if (exp_dm_q.size() == 0) chk("dm_ready_unexpected", 32'd1, 32'd0);
        else chk("dm_rdata", dm_rdata, exp_dm_q.pop_front());
      end
    end
  end

  // cycle-by-cycle expectations for the held dual-request run
  logic [7:0] rr_grant = 8'b0011_0011;
  logic [7:0] rr_dmrdy = 8'b0010_0010;
  logic [7:0] rr_ifrdy = 8'b1000_1000;
  logic [7:0] rr_mreq  = 8'b0101_0101;

  initial begin
    mem_img[32'h0040_0000] = 32'h2408_0005;
    mem_img[32'h0040_0004] = 32'h8D09_0000;
    mem_img[32'h1001_0000] = 32'hDEAD_BEEF;

    // reset values
    step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // single fetch, ack latency 0
    ack_lat = 0;
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    exp_if_q.push_back(32'h2408_0005);
    step();
    chk("f1_mem_req_c1", 32'(mem_req), 32'd1);
    chk("f1_mem_be_c1", 32'(mem_be), 32'hF);
    chk("f1_mem_addr_c1", mem_addr, 32'h0040_0000);
    chk("f1_busy_c1", 32'(busy), 32'd1);
    step();
    chk("f1_if_ready_c2", 32'(if_ready), 32'd1);
    chk("f1_mem_req_c2", 32'(mem_req), 32'd0);
    chk("f1_dm_ready_c2", 32'(dm_ready), 32'd0);
    if_req = 1'b0;
    step();
    chk("f1_if_ready_c3", 32'(if_ready), 32'd0);

    // simultaneous requests right after reset: DM, IF, DM, IF
    rst = 1'b1;
    step();
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0040_0004;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_be   = 4'b1111;
    dm_addr = 32'h1001_0000;
    repeat (2) begin
      exp_dm_q.push_back(32'hDEAD_BEEF);
      exp_if_q.push_back(32'h8D09_0000);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("rr_grant_dm_c%0d", c), 32'(grant_dm), 32'(rr_grant[c-1]));
      chk($sformatf("rr_dm_ready_c%0d", c), 32'(dm_ready), 32'(rr_dmrdy[c-1]));
      chk($sformatf("rr_if_ready_c%0d", c), 32'(if_ready), 32'(rr_ifrdy[c-1]));
      chk($sformatf("rr_mem_req_c%0d", c), 32'(mem_req), 32'(rr_mreq[c-1]));
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    step();
    chk("rr_idle_mem_req", 32'(mem_req), 32'd0);

    // SB with three wait states; dm_rdata must keep the last load value
    ack_lat  = 3;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b0100;
    dm_addr  = 32'h1001_0002;
    dm_wdata = 32'h00AB_0000;
    exp_dm_q.push_back(32'hDEAD_BEEF);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("sb_mem_req_c%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("sb_mem_we_c%0d", c), 32'(mem_we), 32'd1);
      chk($sformatf("sb_mem_be_c%0d", c), 32'(mem_be), 32'h4);
      chk($sformatf("sb_mem_addr_c%0d", c), mem_addr, 32'h1001_0002);
      chk($sformatf("sb_mem_wdata_c%0d", c), mem_wdata, 32'h00AB_0000);
      chk($sformatf("sb_dm_ready_c%0d", c), 32'(dm_ready), 32'd0);
    end
    step();
    chk("sb_dm_ready_c5", 32'(dm_ready), 32'd1);
    chk("sb_mem_req_c5", 32'(mem_req), 32'd0);
    chk("sb_mem_we_c5", 32'(mem_we), 32'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    step();

    // stale request: fetch holds req one cycle past its ready
    ack_lat = 0;
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    exp_if_q.push_back(32'h2408_0005);
    step();
    step();
    chk("stale_if_ready", 32'(if_ready), 32'd1);
    step();
    if_req = 1'b0;
    chk("stale_mem_req", 32'(mem_req), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    step();
    chk("stale_if_ready_after", 32'(if_ready), 32'd0);

    // reset in the middle of a load; a late ack must be ignored
    ack_lat = 1000;
    dm_req  = 1'b1;
    dm_addr = 32'h1001_0000;
    step();
    step();
    chk("rm_mem_req_before", 32'(mem_req), 32'd1);
    chk("rm_grant_before", 32'(grant_dm), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_mem_req_async", 32'(mem_req), 32'd0);
    chk("rm_busy_async", 32'(busy), 32'd0);
    dm_req = 1'b0;
    step();
    rst = 1'b0;
    ack_force = 1'b1;
    step();
    step();
    ack_force = 1'b0;
    chk_reset_vals("rm");
    step();
    chk("rm_dm_ready_late", 32'(dm_ready), 32'd0);

    // every expected response must have been consumed
    chk("if_queue_empty", 32'(exp_if_q.size()), 32'd0);
    chk("dm_queue_empty", 32'(exp_dm_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
